// File: rtl/wb_regfile_if.sv
// Writeback/read-port bundle between the writeback mux, decode/execute and the integer register file.
// The master drives writeback and read indices; the slave (register file) returns read data and instret.
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [31:0]     wb_instruction;
  logic [XLEN-1:0] wb_data;
  logic            wb_enable;
  logic            wb_valid;
  logic            stall;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [63:0]     instret;

  modport master (
    output wb_instruction, wb_data, wb_enable, wb_valid, stall, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, instret
  );

  modport slave (
    input  wb_instruction, wb_data, wb_enable, wb_valid, stall, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, instret
  );
endinterface

// File: rtl/wb_regfile.sv
// Integer register file: one writeback port, two combinational read ports, 64-bit instret counter.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [63:0]     instret_q;
  logic [AW-1:0]   rd;
  logic            retire;
  logic            we;
  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;

  assign rd     = bus.wb_instruction[7 +: AW];
  assign retire = bus.wb_valid & ~bus.stall;
  assign we     = bus.wb_enable & retire & (rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      instret_q <= '0;
    end else begin
      if (we) regs_q[rd] <= bus.wb_data;
      if (retire) instret_q <= instret_q + 64'd1;
    end
  end

  // x0 and reset force zero regardless of any bypass match.
  always_comb begin
    rs1_d = regs_q[bus.rs1_addr];
    rs2_d = regs_q[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (we && bus.rs1_addr == rd) rs1_d = bus.wb_data;
    if (we && bus.rs2_addr == rd) rs2_d = bus.wb_data;
`else
`endif
    if (!rst_n || bus.rs1_addr == '0) rs1_d = '0;
    if (!rst_n || bus.rs2_addr == '0) rs2_d = '0;
  end

  assign bus.rs1_data = rs1_d;
  assign bus.rs2_data = rs2_d;
  assign bus.instret  = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a register/retire-count model checked every cycle plus literal checkpoints.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  wb_regfile_if #(.XLEN(32), .AW(5)) bus ();

  wb_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: architectural registers and a count of retirements since reset.
  logic [31:0] mregs [32];
  logic [63:0] m_count;
  logic [63:0] offset = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [4:0] rd;
    logic       commit;
    rd     = bus.wb_instruction[11:7];
    commit = bus.wb_enable && bus.wb_valid && !bus.stall && rd != 5'd0;
    if (!rst_n || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (commit && a == rd) return bus.wb_data;
`else
    if (commit && a == rd) return mregs[a];
`endif
    return mregs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      m_count = 64'd0;
    end else if (bus.wb_valid && !bus.stall) begin
      m_count = m_count + 64'd1;
      if (bus.wb_enable && bus.wb_instruction[11:7] != 5'd0)
        mregs[bus.wb_instruction[11:7]] = bus.wb_data;
    end
  end

  always @(negedge clk) begin
    check("model_rs1", {32'd0, bus.rs1_data}, {32'd0, model_read(bus.rs1_addr)});
    check("model_rs2", {32'd0, bus.rs2_data}, {32'd0, model_read(bus.rs2_addr)});
    check("model_instret", bus.instret, m_count + offset);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [31:0] d, input logic en,
                       input logic vld, input logic stl);
    bus.wb_instruction = {20'h00000, rd, 7'b0110011};
    bus.wb_data        = d;
    bus.wb_enable      = en;
    bus.wb_valid       = vld;
    bus.stall          = stl;
  endtask

  task automatic idle();
    drive(5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    #2;
    check("reset_rs1", {32'd0, bus.rs1_data}, 64'd0);
    check("reset_instret", bus.instret, 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;

    // x5 = DEADBEEF, then asynchronous reset mid-cycle with a write pending on x6
    drive(5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    check("x5_written", {32'd0, bus.rs1_data}, 64'h0000_0000_DEAD_BEEF);
    check("instret_one", bus.instret, 64'd1);
    drive(5'd6, 32'h55, 1'b1, 1'b1, 1'b0);
    bus.rs2_addr = 5'd6;
    rst_n  = 1'b0;
    offset = 64'd0;
    #1;
    check("async_reset_rs1", {32'd0, bus.rs1_data}, 64'd0);
    check("async_reset_instret", bus.instret, 64'd0);
    cyc();
    idle();
    rst_n = 1'b1;
    #1;
    check("reset_edge_write_lost", {32'd0, bus.rs2_data}, 64'd0);

    // basic write
    drive(5'd7, 32'h12345678, 1'b1, 1'b1, 1'b0);
    cyc();
    idle();
    bus.rs2_addr = 5'd7;
    #1;
    check("basic_rs2", {32'd0, bus.rs2_data}, 64'h1234_5678);
    check("basic_instret", bus.instret, 64'd1);

    // x0 protection
    drive(5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    bus.rs1_addr = 5'd0;
    cyc();
    idle();
    #1;
    check("x0_zero", {32'd0, bus.rs1_data}, 64'd0);
    check("x0_retires", bus.instret, 64'd2);

    // stall two cycles, then a flushed bubble
    drive(5'd3, 32'hAA, 1'b1, 1'b1, 1'b1);
    bus.rs1_addr = 5'd3;
    cyc(); cyc();
    drive(5'd3, 32'hAA, 1'b1, 1'b0, 1'b0);
    cyc();
    idle();
    #1;
    check("stall_x3", {32'd0, bus.rs1_data}, 64'd0);
    check("stall_instret", bus.instret, 64'd2);

    // read during write on x9
    drive(5'd9, 32'h1, 1'b1, 1'b1, 1'b0);
    cyc();
    drive(5'd9, 32'h2, 1'b1, 1'b1, 1'b0);
    bus.rs1_addr = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_commit_cycle", {32'd0, bus.rs1_data}, 64'd2);
`else
    check("rdw_commit_cycle", {32'd0, bus.rs1_data}, 64'd1);
`endif
    cyc();
    idle();
    #1;
    check("rdw_after", {32'd0, bus.rs1_data}, 64'd2);
    check("rdw_instret", bus.instret, 64'd4);

    // store-like retire: counts but no write
    drive(5'd10, 32'h77, 1'b0, 1'b1, 1'b0);
    bus.rs2_addr = 5'd10;
    cyc();
    idle();
    #1;
    check("store_counts", bus.instret, 64'd5);
    check("store_no_write", {32'd0, bus.rs2_data}, 64'd0);

    // counter wrap
    @(posedge clk);
    #1;
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    offset = 64'hFFFF_FFFF_FFFF_FFFF - m_count;
    #1;
    check("preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(5'd11, 32'h3, 1'b1, 1'b1, 1'b0);
    cyc();
    idle();
    #1;
    check("wrap_zero", bus.instret, 64'd0);

    // mixed traffic, checked by the per-cycle model
    for (int i = 1; i < 24; i++) begin
      drive(5'(i), 32'hA5A5_0000 ^ 32'(i * 3), 1'(i % 5 != 0), 1'(i % 7 != 0), 1'(i % 4 == 0));
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(i - 1);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Integer register file for the RISC-V core; directly downstream of the writeback mux.
- Consumes writeback data and writeback enable, plus the destination register field of the retiring instruction.
- Provides two asynchronous read ports to decode/execute.
- Keeps a 64-bit retired-instruction counter for the CSR unit (instret).

Parameters:
- XLEN, 32, data width of each register and of the write/read data.
- NREGS, 32, number of architectural registers (x0..x31); index width is log2(NREGS) = 5.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_instruction  in  32  retiring instruction; rd = wb_instruction[11:7].
- wb_data  in  XLEN  writeback data from the writeback mux.
- wb_enable  in  1  writeback enable from the writeback mux.
- wb_valid  in  1  a real instruction retires this cycle; low for bubbles.
- stall  in  1  writeback stage held; suppresses write and count.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  XLEN  read port 1 data.
- rs2_data  out  XLEN  read port 2 data.
- instret  out  64  count of retired instructions.

Behaviour:
- Write commit condition: we = wb_enable & wb_valid & ~stall & (rd != 0).
- When we is high, regs[rd] <= wb_data on the rising edge of clk.
- x0 is never written; reads of index 0 always return 0, whatever the write activity.
- Reads are combinational: rsN_data = regs[rsN_addr]. Latency 0, no registered read path.
- Write-to-read visibility without the optional feature: a write is visible on the read ports the cycle after its commit edge.
- Reset: asynchronous assertion of rst_n = 0 immediately clears all registers x1..x31 to 0, sets instret to 0, and forces rs1_data = rs2_data = 0.
- Reset deassertion is assumed synchronised upstream.
- Reset mid-operation: a write coinciding with the reset edge is discarded.
- instret: increments by 1 on each edge where wb_valid & ~stall is high, independent of wb_enable and rd. Stores, branches and writes to x0 still retire.
- instret wraps modulo 2^64 from all-ones to 0, with no sticky flag.
- Stall: when stall is high there is no register write and no instret increment. The read ports remain live.
- wb_enable high with wb_valid low (flushed bubble): no write and no count.
- Unknown or X rd is not checked. The only legal qualification is via wb_valid and wb_enable.
- Both read ports may address the same register, or the write target, in the same cycle. No hazard state is kept.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port forwards write data when we is high and rsN_addr == rd, so rsN_data = wb_data in the same cycle as the write.
  - Removes the need for a WB→ID forwarding path in the hazard unit.
  - rsN_addr == 0 still returns 0.
- Not defined:
  - No bypass; reads return the pre-write register value during the commit cycle.
  - The hazard unit must forward or stall.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing x5=0xDEADBEEF → rs1_data(rs1_addr=5)=0 immediately, before any clock edge; instret=0.
- Basic write/read: wb_instruction rd=7, wb_data=0x12345678, wb_enable=1, wb_valid=1 for one edge → next cycle rs2_data(addr 7)=0x12345678; instret=1.
- x0 protection: write rd=0 with wb_data=0xFFFFFFFF, valid and enabled → rs1_data(addr 0)=0; instret still increments by 1.
- Stall/bubble: rd=3, wb_data=0xAA, wb_enable=1 with stall=1 for 2 cycles, then wb_valid=0 for 1 cycle → x3 unchanged (0), instret unchanged.
- Read-during-write, rd=rs1=9, old value 0x1, new 0x2:
  - With REGFILE_BYPASS_EN: rs1_data=0x2 in the commit cycle.
  - Without REGFILE_BYPASS_EN: rs1_data=0x1 in the commit cycle, then 0x2.
- Counter wrap: force instret to 0xFFFFFFFF_FFFFFFFF via hierarchical preload, retire 1 → instret=0; also check one cycle with wb_enable=0 (store) still counts.
